// File: rtl/alu_defs.sv
// rtl/alu_defs.sv - shared opcodes, FSM state encoding and default width for alu_seq
package alu_defs;

    localparam int WIDTH_DEF = 4;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_SLTU = 3'b101;
    localparam logic [2:0] OP_MUL  = 3'b110;
    localparam logic [2:0] OP_LOAD = 3'b111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// rtl/alu_mul_iter.sv - iterative shift-add unsigned multiplier datapath
//
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   load         capture a/b, clear partial product and step counter
//   step         perform one shift-add step
//   a, b         multiplicand / multiplier (WIDTH bits)
//   prod_next    partial product including the current step (2*WIDTH bits)
//   last_step    current step is the final one
module alu_mul_iter #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               step,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] prod_next,
    output logic               last_step
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [CW-1:0]      cnt_q, cnt_d;

    // Exposed combinationally so the top can commit the final step's result
    // on the same edge that performs it.
    assign prod_next = prod_q + (mplier_q[0] ? mcand_q : '0);
    assign last_step = step && (cnt_q == LAST_CNT);

    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        cnt_d    = cnt_q;
        if (load) begin
            mcand_d  = {{WIDTH{1'b0}}, a};
            mplier_d = b;
            prod_d   = '0;
            cnt_d    = '0;
        end else if (step) begin
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            prod_d   = prod_next;
            cnt_d    = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - sequential ALU with accumulator, flags and iterative multiply
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start           issue request (ignored while busy)
//   S, A, B         opcode and operands, sampled with start
//   use_acc         take operand A from the C register
//   C, C_hi         result register, high half of MUL product
//   Co, Zero        carry/flag, result-is-zero
//   busy, done      multiply in progress, one-cycle completion pulse
module alu_seq
    import alu_defs::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       S,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             use_acc,
    output logic [WIDTH-1:0] C,
    output logic [WIDTH-1:0] C_hi,
    output logic             Co,
    output logic             Zero,
    output logic             busy,
    output logic             done
);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   c_q, c_d;
    logic [WIDTH-1:0]   c_hi_q, c_hi_d;
    logic               co_q, co_d;
    logic               zero_q, zero_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [WIDTH-1:0]   a_eff;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_co;
    logic [WIDTH:0]     add_full;
    logic [WIDTH:0]     sub_full;
    logic               mul_load;
    logic               mul_step;
    logic [2*WIDTH-1:0] prod_next;
    logic               mul_last;

    assign a_eff    = use_acc ? c_q : A;
    assign add_full = {1'b0, a_eff} + {1'b0, B};
    // Carry out of A + ~B + 1: 1 means no borrow.
    assign sub_full = {1'b0, a_eff} + {1'b0, ~B} + {{WIDTH{1'b0}}, 1'b1};

    always_comb begin
        alu_res = '0;
        alu_co  = 1'b0;
        case (S)
            OP_ADD:  begin alu_res = add_full[WIDTH-1:0]; alu_co = add_full[WIDTH]; end
            OP_SUB:  begin alu_res = sub_full[WIDTH-1:0]; alu_co = sub_full[WIDTH]; end
            OP_AND:  alu_res = a_eff & B;
            OP_OR:   alu_res = a_eff | B;
            OP_XOR:  alu_res = a_eff ^ B;
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a_eff < B)};
            OP_LOAD: alu_res = B;
            default: alu_res = '0;
        endcase
    end

    assign mul_step = (state_q == ST_MUL);

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk       (clk),
        .rst       (rst),
        .load      (mul_load),
        .step      (mul_step),
        .a         (a_eff),
        .b         (B),
        .prod_next (prod_next),
        .last_step (mul_last)
    );

    always_comb begin
        state_d  = state_q;
        c_d      = c_q;
        c_hi_d   = c_hi_q;
        co_d     = co_q;
        zero_d   = zero_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        mul_load = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (S == OP_MUL) begin
                        mul_load = 1'b1;
                        busy_d   = 1'b1;
                        state_d  = ST_MUL;
                    end else begin
                        c_d    = alu_res;
                        c_hi_d = '0;
                        co_d   = alu_co;
                        zero_d = (alu_res == '0);
                        done_d = 1'b1;
                    end
                end
            end
            ST_MUL: begin
                // start is deliberately not examined here: no queueing.
                if (mul_last) begin
                    c_d     = prod_next[WIDTH-1:0];
                    c_hi_d  = prod_next[2*WIDTH-1:WIDTH];
                    co_d    = |prod_next[2*WIDTH-1:WIDTH];
                    zero_d  = (prod_next == '0);
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            c_q     <= '0;
            c_hi_q  <= '0;
            co_q    <= 1'b0;
            zero_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            c_hi_q  <= c_hi_d;
            co_q    <= co_d;
            zero_q  <= zero_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign C    = c_q;
    assign C_hi = c_hi_q;
    assign Co   = co_q;
    assign Zero = zero_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised sequential ALU: the next generation of the 4-bit combinational ALU, with a WIDTH-bit datapath and 3-bit opcode. It adds a result/accumulator register, status flags, an iterative shift-add multiplier and a start/busy/done handshake. It is a registered execution unit for the lab datapath: a controller issues one operation per start pulse and consumes the result on done.

## Interface
- WIDTH, 4, operand/result width in bits (≥2)
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  issue request; sampled only when busy=0
- S  in  3  opcode, sampled with start
- A  in  WIDTH  operand A, sampled with start
- B  in  WIDTH  operand B, sampled with start
- use_acc  in  1  when 1, operand A is the current C register instead of port A
- C  out  WIDTH  result register (accumulator), low half for MUL
- C_hi  out  WIDTH  high half of MUL product; 0 for all other ops
- Co  out  1  carry/flag (see Operation)
- Zero  out  1  1 when C==0 and C_hi==0
- busy  out  1  multiply in progress
- done  out  1  one-cycle pulse: result registers just updated

## Operation
- Opcodes:
  - 000 ADD: C=A+B, Co=carry out
  - 001 SUB: C=A−B, computed as A+~B+1; Co=carry out (1 = no borrow)
  - 010 AND, 011 OR, 100 XOR: Co=0
  - 101 SLTU: C=1 if A<B unsigned else 0; Co=0
  - 110 MUL: unsigned, iterative; {C_hi,C}=A*B; Co=1 iff C_hi≠0
  - 111 LOAD: C=B; Co=0
- Effective operand A is the C register value at the sampling edge when use_acc=1.
- All arithmetic is modulo 2^WIDTH; C_hi is forced to 0 for non-MUL ops.
- FSM states:
  - IDLE: start=1 with a non-MUL opcode updates C/C_hi/Co/Zero at that edge and sets done for the next cycle; stays in IDLE.
  - IDLE → MUL: start=1 with S=110 latches operands, clears the partial product and counter, and sets busy.
  - MUL: one shift-add step per cycle. After WIDTH steps, loads C, C_hi, Co and Zero, clears busy, pulses done, and returns to IDLE.
- start while busy=1 is ignored: no queueing, no effect on the running MUL.
- Outputs hold their last values between operations.

## Timing
- Reset values: C=0, C_hi=0, Co=0, Zero=1, busy=0, done=0, FSM=IDLE, counter=0.
- Non-MUL latency: start sampled at edge k → results and done=1 visible after edge k; done returns to 0 after edge k+1 unless a new op issues.
- Back-to-back single-cycle ops: start may be held high every cycle; each edge completes one op and done stays high.
- MUL latency: start at edge k → busy=1 after edge k through edge k+WIDTH−1. Results and done=1 appear after edge k+WIDTH, busy=0 then. A new start is accepted at edge k+WIDTH+1 at the earliest.
- Reset mid-MUL: immediate abort, all outputs take reset values, and no done pulse follows.
- Operand ports may change freely after the sampling edge.

## Structure
- Shared package/header alu_defs: opcode localparams (OP_ADD … OP_LOAD), FSM state encoding (ST_IDLE, ST_MUL), and the WIDTH default.
- One sub-module, alu_mul_iter: holds the shift-add multiplier datapath (multiplicand, multiplier shift register, 2·WIDTH partial product, step counter). It has load/step inputs and a last-step output.
- The top level holds the FSM, single-cycle combinational ops, result registers and flag logic.

## Test plan
All cases use WIDTH=4.
- Reset: assert rst asynchronously mid-cycle → C=0000, C_hi=0000, Co=0, Zero=1, busy=0, done=0 without waiting for a clock edge.
- ADD: A=0110, B=1010, S=000, one start → C=0000, Co=1, Zero=1, done high exactly one cycle.
- SUB/SLTU: A=0011, B=1010, S=001 → C=1001, Co=0; then S=101 → C=0001, Co=0, Zero=0.
- MUL: A=1111, B=1010, S=110 → busy high 4 cycles, then C=0110, C_hi=1001, Co=1, single done pulse. Start pulses during busy leave the result unchanged.
- Accumulate: S=111, B=0000; then use_acc=1, S=000, B=0011, start held high three cycles → C=0011, 0110, 1001 on successive cycles, done high throughout.
- Abort: start MUL A=0111, B=0101, assert rst after 2 cycles → all outputs at reset values, no done. A subsequent MUL completes normally with C=0011, C_hi=0010 (35).
